// File: rtl/serial_subtract_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtract_pkg
//   Shared definitions for the serial subtractor:
//     state_e      - FSM state encoding (IDLE / RUN / DONE)
//     num_digits() - number of RUN cycles for a WIDTH/DIGIT pair
// -----------------------------------------------------------------------------
package serial_subtract_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of DIGIT-wide slices needed to cover WIDTH bits.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage : serial_subtract_pkg

// File: rtl/digit_subtract.sv
// -----------------------------------------------------------------------------
// digit_subtract
//   Combinational DIGIT-bit ripple-borrow subtractor slice: d = x - y - br_in.
//   Ports:
//     x      in  DIGIT  minuend slice
//     y      in  DIGIT  subtrahend slice
//     br_in  in  1      borrow into bit 0
//     d      out DIGIT  difference slice
//     br_out out 1      borrow out of the top bit
// -----------------------------------------------------------------------------
module digit_subtract #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             br_in,
  output logic [DIGIT-1:0] d,
  output logic             br_out
);

  // NOTE: every signal written in always_comb gets a value before any branch
  // or loop touches it; otherwise synthesis infers a latch.
  always_comb begin
    logic w_br;
    w_br = br_in;
    d    = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d[i] = x[i] ^ y[i] ^ w_br;
      // Borrow when y beats x outright, or when they tie and a borrow is pending.
      w_br = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & w_br);
    end
    br_out = w_br;
  end

endmodule : digit_subtract

// File: rtl/serial_subtract.sv
// -----------------------------------------------------------------------------
// serial_subtract
//   Multi-cycle subtractor: diff = a - b - bin (mod 2^WIDTH), DIGIT bits per
//   clock, LSB first, with a registered borrow between cycles.
//   Handshake: start is accepted while ready=1; valid pulses one cycle when
//   diff/bout (and ovf) are final. Latency from the accepting edge is N+1
//   cycles, throughput one operation per N+2 cycles, N = WIDTH/DIGIT.
//   Ports:
//     clk    in  1      clock, rising edge
//     rst    in  1      synchronous active-high reset
//     start  in  1      request, sampled only while ready=1
//     a      in  WIDTH  minuend
//     b      in  WIDTH  subtrahend
//     bin    in  1      borrow-in
//     ready  out 1      idle, can accept start
//     busy   out 1      operation in progress (RUN or DONE)
//     valid  out 1      one-cycle result strobe
//     diff   out WIDTH  difference, held until the next result
//     bout   out 1      borrow-out (a < b + bin), held with diff
//     ovf    out 1      signed overflow, only when SERIAL_SUBTRACT_OVF_EN is
//                       defined
//   Optional feature macro: SERIAL_SUBTRACT_OVF_EN
// -----------------------------------------------------------------------------
module serial_subtract
  import serial_subtract_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACT_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = num_digits(WIDTH, DIGIT);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_subtract: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
           WIDTH, DIGIT);
  end

  state_e             r_state;
  state_e             w_state_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_diff;
  logic               r_br;
  logic               r_bout;
  logic               r_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic [DIGIT-1:0]   w_d;
  logic               w_br_out;
  logic               w_last;
  logic [WIDTH+DIGIT-1:0] w_res_cat;

`ifdef SERIAL_SUBTRACT_OVF_EN
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_ovf;
`endif

  // Low digit of each shifting operand against the registered borrow.
  digit_subtract #(
    .DIGIT (DIGIT)
  ) u_digit (
    .x      (r_a[DIGIT-1:0]),
    .y      (r_b[DIGIT-1:0]),
    .br_in  (r_br),
    .d      (w_d),
    .br_out (w_br_out)
  );

  assign w_last = (r_cnt == CNT_W'(N - 1));

  // New digit enters at the MSB end; concatenating first keeps the slice legal
  // even when DIGIT == WIDTH.
  assign w_res_cat = {w_d, r_res};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    case (r_state)
      IDLE:      ready = 1'b1;
      RUN, DONE: busy  = 1'b1;
      default:   ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_diff  <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_SUBTRACT_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
`ifdef SERIAL_SUBTRACT_OVF_EN
            // Operand MSBs shift out during RUN, so keep them for the flag.
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_res <= w_res_cat[WIDTH+DIGIT-1:DIGIT];
          r_br  <= w_br_out;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        DONE: begin
          r_diff  <= r_res;
          r_bout  <= r_br;
          r_valid <= 1'b1;
`ifdef SERIAL_SUBTRACT_OVF_EN
          r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_res[WIDTH-1]);
`endif
        end
        default: ;
      endcase
    end
  end

  assign valid = r_valid;
  assign diff  = r_diff;
  assign bout  = r_bout;
`ifdef SERIAL_SUBTRACT_OVF_EN
  assign ovf   = r_ovf;
`endif

endmodule : serial_subtract

// File: tb/tb_serial_subtract.sv
// -----------------------------------------------------------------------------
// tb_serial_subtract
//   Scoreboard bench for serial_subtract. Four instances share one clock:
//     inst 0: WIDTH=8, DIGIT=1   (latency 9)
//     inst 1: WIDTH=8, DIGIT=4   (latency 3)
//     inst 2: WIDTH=8, DIGIT=8   (latency 2)
//     inst 3: WIDTH=4, DIGIT=2   (latency 3, exhaustive sweep)
//   The driver pushes the expected result and the start-edge cycle into a
//   queue; the monitor pops on every valid and checks value and latency.
//   Honours SERIAL_SUBTRACT_OVF_EN for the ovf port.
// -----------------------------------------------------------------------------
module tb_serial_subtract;

  localparam int NI = 4;

  typedef struct {
    int         inst;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    int         start_cyc;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_a;   // inst 0
  logic                rst_b;   // inst 1..3
  logic [NI-1:0]       start_s;
  logic [NI-1:0][7:0]  a_s;
  logic [NI-1:0][7:0]  b_s;
  logic [NI-1:0]       bin_s;
  logic [NI-1:0]       ready_s;
  logic [NI-1:0]       busy_s;
  logic [NI-1:0]       valid_s;
  logic [NI-1:0]       bout_s;
  logic [NI-1:0][7:0]  diff_s;
  logic [3:0]          w4_diff;
`ifdef SERIAL_SUBTRACT_OVF_EN
  logic [NI-1:0]       ovf_s;
`endif

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  serial_subtract #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst_a), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]), .bin(bin_s[0]),
    .ready(ready_s[0]), .busy(busy_s[0]), .valid(valid_s[0]), .diff(diff_s[0]), .bout(bout_s[0])
`ifdef SERIAL_SUBTRACT_OVF_EN
    , .ovf(ovf_s[0])
`endif
  );

  serial_subtract #(.WIDTH(8), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst_b), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]), .bin(bin_s[1]),
    .ready(ready_s[1]), .busy(busy_s[1]), .valid(valid_s[1]), .diff(diff_s[1]), .bout(bout_s[1])
`ifdef SERIAL_SUBTRACT_OVF_EN
    , .ovf(ovf_s[1])
`endif
  );

  serial_subtract #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst_b), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]), .bin(bin_s[2]),
    .ready(ready_s[2]), .busy(busy_s[2]), .valid(valid_s[2]), .diff(diff_s[2]), .bout(bout_s[2])
`ifdef SERIAL_SUBTRACT_OVF_EN
    , .ovf(ovf_s[2])
`endif
  );

  serial_subtract #(.WIDTH(4), .DIGIT(2)) u_w4 (
    .clk(clk), .rst(rst_b), .start(start_s[3]), .a(a_s[3][3:0]), .b(b_s[3][3:0]), .bin(bin_s[3]),
    .ready(ready_s[3]), .busy(busy_s[3]), .valid(valid_s[3]), .diff(w4_diff), .bout(bout_s[3])
`ifdef SERIAL_SUBTRACT_OVF_EN
    , .ovf(ovf_s[3])
`endif
  );

  assign diff_s[3] = {4'h0, w4_diff};

  function automatic int lat_of(input int k);
    case (k)
      0:       return 9;
      1:       return 3;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every valid must match the oldest outstanding expectation.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (valid_s[k]) begin
        if (q.size() == 0) begin
          fail_now($sformatf("unexpected valid on inst%0d", k));
        end else begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("inst%0d result owner", k), k, e.inst);
          check($sformatf("inst%0d diff", k), diff_s[k], e.diff);
          check($sformatf("inst%0d bout", k), bout_s[k], e.bout);
`ifdef SERIAL_SUBTRACT_OVF_EN
          check($sformatf("inst%0d ovf", k), ovf_s[k], e.ovf);
`endif
          check($sformatf("inst%0d latency", k), cyc - e.start_cyc, lat_of(k));
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb, input logic eo, input bit push);
    int guard;
    guard = 0;
    while (!ready_s[k] && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_s[k]) begin
      fail_now($sformatf("inst%0d ready timeout", k));
      return;
    end
    start_s[k] = 1'b1;
    a_s[k]     = a;
    b_s[k]     = b;
    bin_s[k]   = bin;
    if (push) q.push_back('{k, ed, eb, eo, cyc + 1});
    @(negedge clk);
    // Scramble operands so a late sample would corrupt the result.
    start_s[k] = 1'b0;
    a_s[k]     = ~a;
    b_s[k]     = ~b;
    bin_s[k]   = ~bin;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() != 0) fail_now("drain timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    int   s;
    int   guard;

    // a, b, bin, diff, bout, ovf (hand computed)
    vecs = '{
      '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0},
      '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0},
      '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1},
      '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0},
      '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0},
      '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0},
      '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1},
      '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1},
      '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0}
    };

    rst_a   = 1'b1;
    rst_b   = 1'b1;
    start_s = '0;
    a_s     = '0;
    b_s     = '0;
    bin_s   = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset ready inst%0d", k), ready_s[k], 1);
      check($sformatf("reset busy inst%0d", k),  busy_s[k],  0);
      check($sformatf("reset valid inst%0d", k), valid_s[k], 0);
      check($sformatf("reset diff inst%0d", k),  diff_s[k],  0);
      check($sformatf("reset bout inst%0d", k),  bout_s[k],  0);
`ifdef SERIAL_SUBTRACT_OVF_EN
      check($sformatf("reset ovf inst%0d", k),   ovf_s[k],   0);
`endif
    end

    // Directed vectors on the three 8-bit variants, issued back to back
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 9; i++)
        issue(k, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ov, 1'b1);
      drain();
    end

    // Start while busy is ignored; ready stays low until IDLE
    issue(0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    s = cyc;
    repeat (2) @(negedge clk);
    start_s[0] = 1'b1;
    a_s[0]     = 8'h55;
    b_s[0]     = 8'h00;
    bin_s[0]   = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0;
    check("busy while running", busy_s[0], 1);
    check("ready while running", ready_s[0], 0);
    guard = 0;
    while (!ready_s[0] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("ready return cycle", cyc - s, 9);
    drain();

    // Reset mid-operation discards the partial result
    issue(0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("abort ready", ready_s[0], 1);
    check("abort busy",  busy_s[0],  0);
    check("abort valid", valid_s[0], 0);
    check("abort diff",  diff_s[0],  0);
    check("abort bout",  bout_s[0],  0);
    rst_a = 1'b0;
    repeat (12) @(negedge clk);
    issue(0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
    drain();

    // Exhaustive WIDTH=4, DIGIT=2 against a reference model
    for (int ea = 0; ea < 16; ea++) begin
      for (int eb = 0; eb < 16; eb++) begin
        for (int ec = 0; ec < 2; ec++) begin
          int         t;
          logic [3:0] d4;
          logic [3:0] a4;
          logic [3:0] b4;
          t  = ea - eb - ec;
          d4 = 4'(t & 15);
          a4 = 4'(ea);
          b4 = 4'(eb);
          issue(3, {4'h0, a4}, {4'h0, b4}, ec[0], {4'h0, d4}, (t < 0),
                (a4[3] ^ b4[3]) & (a4[3] ^ d4[3]), 1'b1);
        end
      end
    end
    drain();

    check("scoreboard empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_serial_subtract
